// File: rtl/la_cellbist3.sv
// -----------------------------------------------------------------------------
// la_cellbist3 : sequential self-test exerciser for 3-input / 1-output cells.
//
// Drives all eight input vectors {b0,a1,a0} onto a cell under test. It repeats
// the sweep loops+1 times and compares the cell output z against the truth
// table TT. It counts mismatches (saturating) and records the first failing
// vector. At the end of the run it reports pass/fail with a one-cycle done
// pulse.
//
// Parameters
//   PROP   : implementation property string for target-specific mapping
//   TT     : expected truth table, TT[v] = z for v = {b0,a1,a0} (OAI21 default)
//   SETTLE : extra hold cycles per vector before z is sampled (0 allowed)
//   LOOPW  : width of the pass-count input
//   ERRW   : width of the mismatch counter
//
// Ports
//   clk      : clock, all state on rising edge
//   nreset   : asynchronous active-low reset
//   start    : run request, honoured only in IDLE
//   loops    : number of passes minus one, latched on accepted start
//   busy     : run in progress
//   done     : one-cycle pulse at end of run
//   pass     : last run had zero mismatches (held until next accepted start)
//   errcnt   : saturating mismatch count of last/current run
//   fail_vec : first mismatching vector of last/current run (0 if none)
//   a0/a1/b0 : registered drive to the cell under test (v[0], v[1], v[2])
//   z        : cell under test output
//
// Build option
//   LA_CELLBIST3_SYNC_EN : z passes through a 2-flop synchronizer before the
//                          compare, and each hold window grows to SETTLE+3.
// -----------------------------------------------------------------------------
module la_cellbist3 #(
   parameter             PROP   = "DEFAULT",
   parameter logic [7:0] TT     = 8'h1F,
   parameter int         SETTLE = 2,
   parameter int         LOOPW  = 8,
   parameter int         ERRW   = 8
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             start,
   input  logic [LOOPW-1:0] loops,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERRW-1:0]  errcnt,
   output logic [2:0]       fail_vec,
   output logic             a0,
   output logic             a1,
   output logic             b0,
   input  logic             z
);

`ifdef LA_CELLBIST3_SYNC_EN
   // Two extra cycles cover the synchronizer latency.
   localparam int HOLD = SETTLE + 3;
`else
   localparam int HOLD = SETTLE + 1;
`endif
   localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [ERRW-1:0] ERR_MAX = '1;

   // Target-specific mapping is selected here. The generic build uses plain RTL.
   if (PROP != "DEFAULT") begin : g_prop_map
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       vec;
   logic [HW-1:0]    hcnt;
   logic [LOOPW-1:0] pcnt;
   logic [LOOPW-1:0] loops_q;
   logic             first_fail;
   logic             z_cmp;
   logic             accept, sample, mismatch, last_sample;
   logic [ERRW-1:0]  errcnt_nxt;

`ifdef LA_CELLBIST3_SYNC_EN
   logic z_s1, z_s2;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         z_s1 <= 1'b0;
         z_s2 <= 1'b0;
      end else begin
         z_s1 <= z;
         z_s2 <= z_s1;
      end
   end

   assign z_cmp = z_s2;
`else
   assign z_cmp = z;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      sample      = 1'b0;
      mismatch    = 1'b0;
      last_sample = 1'b0;
      errcnt_nxt  = errcnt;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // z is judged only on the final cycle of each hold window.
            sample      = (hcnt == HOLD_LAST);
            mismatch    = sample && (z_cmp != TT[vec]);
            last_sample = sample && (vec == 3'd7) && (pcnt == loops_q);
            if (mismatch && (errcnt != ERR_MAX)) errcnt_nxt = errcnt + 1'b1;
            if (last_sample) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         vec        <= '0;
         hcnt       <= '0;
         pcnt       <= '0;
         loops_q    <= '0;
         errcnt     <= '0;
         fail_vec   <= '0;
         pass       <= 1'b0;
         first_fail <= 1'b0;
      end else if (accept) begin
         loops_q    <= loops;
         vec        <= '0;
         hcnt       <= '0;
         pcnt       <= '0;
         errcnt     <= '0;
         fail_vec   <= '0;
         pass       <= 1'b0;
         first_fail <= 1'b0;
      end else if (state == RUN) begin
         errcnt <= errcnt_nxt;
         if (mismatch && !first_fail) begin
            fail_vec   <= vec;
            first_fail <= 1'b1;
         end
         if (sample) begin
            hcnt <= '0;
            if (last_sample) begin
               // Park the pins on vector 0. The verdict includes the final
               // sample, so it is taken from errcnt_nxt.
               vec  <= '0;
               pass <= (errcnt_nxt == '0);
            end else begin
               vec <= vec + 3'd1;
               if (vec == 3'd7) pcnt <= pcnt + 1'b1;
            end
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign a0   = vec[0];
   assign a1   = vec[1];
   assign b0   = vec[2];

endmodule

// File: tb/tb_la_cellbist3.sv
// -----------------------------------------------------------------------------
// tb_la_cellbist3 : scoreboard bench for la_cellbist3.
// Instance A: SETTLE=2, ERRW=8. Instance B: SETTLE=0, ERRW=4.
// The z model selects one of three behaviours: ideal OAI21, stuck-at-1 or
// stuck-at-0.
// -----------------------------------------------------------------------------
module tb_la_cellbist3;
   localparam int SET_A = 2;
   localparam int SET_B = 0;
`ifdef LA_CELLBIST3_SYNC_EN
   localparam int HOLD_A = SET_A + 3;
   localparam int HOLD_B = SET_B + 3;
`else
   localparam int HOLD_A = SET_A + 1;
   localparam int HOLD_B = SET_B + 1;
`endif

   typedef struct {
      int cyc;
      int err;
      int fv;
      int pss;
   } exp_t;

   exp_t sbq[$];

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [7:0] loops_a = '0, loops_b = '0;
   int         mode_a = 0, mode_b = 0;
   logic       sel = 1'b0;

   logic       busy_a, done_a, pass_a, a0_a, a1_a, b0_a, z_a;
   logic [7:0] err_a;
   logic [2:0] fv_a;
   logic       busy_b, done_b, pass_b, a0_b, a1_b, b0_b, z_b;
   logic [3:0] err_b;
   logic [2:0] fv_b;

   logic       o_busy, o_done, o_pass;
   logic [7:0] o_err;
   logic [2:0] o_fv, o_vec;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // Cell models: an ideal OAI21, or z stuck at a constant.
   assign z_a = (mode_a == 0) ? ~((a0_a | a1_a) & b0_a) : (mode_a == 1);
   assign z_b = (mode_b == 0) ? ~((a0_b | a1_b) & b0_b) : (mode_b == 1);

   la_cellbist3 #(.SETTLE(SET_A), .LOOPW(8), .ERRW(8)) dut_a (
      .clk(clk), .nreset(nreset), .start(start_a), .loops(loops_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .errcnt(err_a),
      .fail_vec(fv_a), .a0(a0_a), .a1(a1_a), .b0(b0_a), .z(z_a));

   la_cellbist3 #(.SETTLE(SET_B), .LOOPW(8), .ERRW(4)) dut_b (
      .clk(clk), .nreset(nreset), .start(start_b), .loops(loops_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .errcnt(err_b),
      .fail_vec(fv_b), .a0(a0_b), .a1(a1_b), .b0(b0_b), .z(z_b));

   always_comb begin
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      o_pass = sel ? pass_b : pass_a;
      o_err  = sel ? {4'b0000, err_b} : err_a;
      o_fv   = sel ? fv_b : fv_a;
      o_vec  = sel ? {b0_b, a1_b, a0_b} : {b0_a, a1_a, a0_a};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      else             n_pass++;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_pass"}, o_pass, 0);
      chk({tag, "_errcnt"}, o_err, 0);
      chk({tag, "_failvec"}, o_fv, 0);
      chk({tag, "_pins"}, o_vec, 0);
   endtask

   // Runs one test. The mode argument selects the z model: 0 ideal,
   // 1 stuck-at-1, 2 stuck-at-0. If poke is set, start is pulsed during the
   // run. A nonzero rst_at asserts nreset in that cycle of the run.
   task automatic run(input bit s, input int mode, input int lps, input bit poke, input int rst_at);
      exp_t       e;
      int         hold, emax, err, fv, c;
      bit         ff, got_done;
      logic [2:0] vb;
      logic       zi, zm;
      sel  = s;
      hold = s ? HOLD_B : HOLD_A;
      emax = s ? 15 : 255;
      err  = 0; fv = 0; ff = 0;
      for (int p = 0; p <= lps; p++) begin
         for (int v = 0; v < 8; v++) begin
            vb = v[2:0];
            zi = ~((vb[0] | vb[1]) & vb[2]);
            zm = (mode == 0) ? zi : (mode == 1);
            if (zm !== zi) begin
               err++;
               if (!ff) begin fv = v; ff = 1; end
            end
         end
      end
      if (err > emax) err = emax;
      e.cyc = 8 * (lps + 1) * hold + 1;
      e.err = err;
      e.fv  = fv;
      e.pss = (err == 0) ? 1 : 0;
      sbq.push_back(e);

      @(negedge clk);
      if (s) begin mode_b = mode; loops_b = lps[7:0]; start_b = 1'b1; end
      else   begin mode_a = mode; loops_a = lps[7:0]; start_a = 1'b1; end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      // Changing loops after acceptance must not alter the run.
      loops_a = ~lps[7:0]; loops_b = ~lps[7:0];

      c = 1; got_done = 0;
      while (!got_done && c <= e.cyc + 20) begin
         if (rst_at != 0 && c == rst_at) begin
            #2 nreset = 1'b0;
            #1;
            chk_zero("midrst");
            e = sbq.pop_front();
            @(negedge clk);
            nreset = 1'b1;
            return;
         end
         if (poke && c == 5) begin start_a = 1'b1; start_b = 1'b1; end
         if (poke && c == 6) begin start_a = 1'b0; start_b = 1'b0; end
         if (o_done) begin
            got_done = 1;
            e = sbq.pop_front();
            chk("done_cycle", c, e.cyc);
            chk("errcnt", o_err, e.err);
            chk("fail_vec", o_fv, e.fv);
            chk("pass", o_pass, e.pss);
            chk("busy_at_done", o_busy, 0);
            chk("pins_at_done", o_vec, 0);
         end else begin
            chk("busy", o_busy, (c < e.cyc) ? 1 : 0);
            chk("pins", o_vec, ((c - 1) / hold) % 8);
         end
         c++;
         @(posedge clk); #1;
      end
      start_a = 1'b0; start_b = 1'b0;
      if (!got_done) begin
         chk("done_timeout", 0, 1);
         e = sbq.pop_front();
      end else begin
         chk("done_one_cycle", o_done, 0);
         chk("pass_held", o_pass, e.pss);
         chk("idle_busy", o_busy, 0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      sel = 1'b0; #1 chk_zero("rst_a");
      sel = 1'b1; #1 chk_zero("rst_b");
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk); #1;
      sel = 1'b0; #1 chk_zero("post_rst_a");

      run(1'b0, 0, 0, 1'b0, 0);   // ideal OAI21, one pass
      run(1'b0, 1, 0, 1'b0, 0);   // stuck-at-1: vectors 5,6,7 fail
      run(1'b0, 2, 3, 1'b0, 0);   // stuck-at-0, four passes
      run(1'b1, 1, 7, 1'b0, 0);   // narrow counter saturates
      run(1'b1, 0, 1, 1'b0, 0);   // SETTLE=0, ideal, two passes
      run(1'b0, 0, 0, 1'b1, 0);   // start pulsed while busy
      run(1'b0, 2, 0, 1'b0, 10);  // reset in cycle 10 of a run
      run(1'b0, 0, 0, 1'b0, 0);   // clean run after reset

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
